// File: rtl/alu32_seq_if.sv
// Request/response bundle between the register-read stage and the ALU core.
// master drives operands and start; slave returns registered results and handshake.
interface alu32_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output start, op, A, B,
    input  result, result_hi, zero, ovf, busy, done
  );

  modport slave (
    input  start, op, A, B,
    output result, result_hi, zero, ovf, busy, done
  );
endinterface

// File: rtl/alu32_seq.sv
// Multi-cycle 32-bit ALU: single-cycle logic/arith ops plus a 32-iteration
// shift-add multiplier, all results and flags registered behind start/done.
module alu32_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  alu32_seq_if.slave  bus
);

  localparam int             CW   = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_NOR  = 3'b100,
    OP_SLT  = 3'b101,
    OP_SUB  = 3'b110,
    OP_MULT = 3'b111
  } op_e;

  state_e state_q, state_d;

  // Latched request
  op_e               op_q;
  logic [WIDTH-1:0]  a_q, b_q;

  // Multiplier state: product/multiplier register and iteration count
  logic [2*WIDTH-1:0] p_q;
  logic [CW-1:0]      count_q;

  // Registered outputs
  logic [WIDTH-1:0]  result_q, result_hi_q;
  logic              zero_q, ovf_q, busy_q, done_q;

  // Decoded controls
  logic accept, exec_fire, mul_step, mul_last;

  // Combinational datapath
  logic [WIDTH-1:0]   sum, diff, alu_result;
  logic               alu_ovf, slt;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] p_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first; a path that leaves it
  // unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start) state_d = (bus.op == OP_MULT) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_IDLE;
      S_MUL:  if (count_q == LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = 1'b0;
    exec_fire = 1'b0;
    mul_step  = 1'b0;
    mul_last  = 1'b0;
    unique case (state_q)
      S_IDLE: accept    = bus.start;
      S_EXEC: exec_fire = 1'b1;
      S_MUL: begin
        mul_step = 1'b1;
        mul_last = (count_q == LAST);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single-cycle function unit on the latched operands
  // ---------------------------------------------------------------------------
  always_comb begin
    sum        = a_q + b_q;
    diff       = a_q - b_q;
    slt        = ($signed(a_q) < $signed(b_q));
    alu_result = '0;
    alu_ovf    = 1'b0;
    unique case (op_q)
      OP_AND: alu_result = a_q & b_q;
      OP_OR:  alu_result = a_q | b_q;
      OP_ADD: begin
        alu_result = sum;
        alu_ovf    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_XOR: alu_result = a_q ^ b_q;
      OP_NOR: alu_result = ~(a_q | b_q);
      OP_SLT: alu_result = {{(WIDTH-1){1'b0}}, slt};
      OP_SUB: begin
        alu_result = diff;
        alu_ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      // MULT never reaches EXEC; the value here is never registered.
      OP_MULT: alu_result = '0;
      default: alu_result = '0;
    endcase
  end

  // One shift-add iteration: conditional add into the high half with carry,
  // then the 65-bit {carry, P} shifts right by one.
  always_comb begin
    partial = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_next  = {partial, p_q[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // Operand latch and multiplier registers
  // ---------------------------------------------------------------------------
  // NOTE: these hold no reset: they are always loaded on accept before any
  // state reads them, and reset alone parks the FSM in IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q     <= bus.A;
      b_q     <= bus.B;
      op_q    <= op_e'(bus.op);
      p_q     <= {{WIDTH{1'b0}}, bus.B};
      count_q <= '0;
    end else if (mul_step) begin
      p_q     <= p_next;
      count_q <= count_q + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Result, flag and handshake registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) busy_q <= 1'b1;
      if (exec_fire) begin
        result_q    <= alu_result;
        result_hi_q <= '0;
        zero_q      <= (alu_result == '0);
        ovf_q       <= alu_ovf;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end else if (mul_last) begin
        result_q    <= p_next[WIDTH-1:0];
        result_hi_q <= p_next[2*WIDTH-1:WIDTH];
        zero_q      <= (p_next[WIDTH-1:0] == '0);
        ovf_q       <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
